// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: combinational hits, single-word
// fills from the memory controller through a two-state IDLE/FILL machine.
module icache #(
    parameter int NSETS = 16,
    parameter int IDXW  = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [NSETS-1:0]  valid;
    logic [TAGW-1:0]   tags [NSETS];
    logic [31:0]       data [NSETS];
    logic [29:0]       missword;
    logic              iren_q;

    logic [IDXW-1:0]   ridx, fidx;
    logic [TAGW-1:0]   rtag, ftag;
    logic              lookup, fill_done;
    logic              unused;

    assign ridx = imemaddr[IDXW+1:2];
    assign rtag = imemaddr[31:IDXW+2];
    assign fidx = missword[IDXW-1:0];
    assign ftag = missword[29:IDXW];
    assign unused = &{1'b0, imemaddr[1:0]};

    assign lookup    = valid[ridx] && (tags[ridx] == rtag);
    // Hits are masked for the whole fill so a lookup never races the frame write.
    assign ihit      = imemREN && (state == IDLE) && lookup;
    assign imemload  = ihit ? data[ridx] : '0;
    assign fill_done = (state == FILL) && !iwait;

    assign iREN  = iren_q;
    assign iaddr = iren_q ? {missword, 2'b00} : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            valid    <= '0;
            missword <= '0;
            iren_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !lookup) begin
                        missword <= imemaddr[31:2];
                        iren_q   <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        valid[fidx] <= 1'b1;
                        iren_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data need no reset; an async reset forces IDLE so no write can slip through.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fidx] <= ftag;
            data[fidx] <= iload;
        end
    end
endmodule
